ads124s08_spi_responder: RTL

- Synthesizable SPI slave that models the ADS124S08 device end of the ADC link.
- Sits on the board-emulation / loopback side, so the ADC master controller can be exercised in simulation and on hardware without a real ADC.
- Decodes single-register WREG/RREG frames and "read data direct" frames (NOP opcode, 32 clocks).
- Holds an 18-entry register file, serves 24-bit conversion words plus a trailing byte, and drives nDRDY.

---
 rtl/ads124s08_spi_responder.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/ads124s08_spi_responder.sv
// ADS124S08 device-side SPI responder (SPI mode 1) for board emulation / loopback.
// Decodes single-register WREG/RREG frames and 32-clock read-data-direct frames,
// keeps an 18-entry register file, serves conversion words and drives nDRDY.
// Optional: define ADS124S08_RESP_CRC_EN to append a CRC-8 of the 24 data bits
// as the tail byte; otherwise the tail byte is 8'h00 and no CRC logic exists.
module ads124s08_spi_responder #(
    parameter logic [7:0] DEVICE_ID   = 8'h08,
    parameter int         REG_COUNT   = 18,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ADC_SCLK,
    input  logic        ADC_nCS,
    input  logic        ADC_MOSI,
    output logic        ADC_MISO,
    output logic        ADC_nDRDY,
    input  logic [23:0] CONV_DATA,
    input  logic        CONV_VALID,
    output logic        REG_WR_STROBE,
    output logic [4:0]  REG_WR_ADDR,
    output logic [7:0]  REG_WR_DATA,
    output logic        FRAME_ERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ARG,
        ST_DATA,
        ST_DIRECT,
        ST_DONE
    } state_t;

    localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   ncs_prev;
    logic                   sclk_s;
    logic                   ncs_s;
    logic                   mosi_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   ncs_rise;
    logic                   ncs_fall;

    state_t      state;
    logic [5:0]  bit_cnt;
    logic [6:0]  rx_shift;
    logic [7:0]  next_byte;
    logic [31:0] shift_out;
    logic [4:0]  out_idx;
    logic [4:0]  reg_addr;
    logic        is_wreg;
    logic        direct_24;
    logic        addr_in_range;
    logic [7:0]  rd_val;
    logic [7:0]  reg_file [1:REG_COUNT-1];

    logic [23:0] conv_data;
    logic [7:0]  conv_tail;
    logic [23:0] pend_data;
    logic        pending;
    logic [23:0] new_word;
    logic [7:0]  new_tail;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign ncs_rise  = ncs_s & ~ncs_prev;
    assign ncs_fall  = ~ncs_s & ncs_prev;

    assign next_byte     = {rx_shift, mosi_s};
    assign out_idx       = 5'd31 - bit_cnt[4:0];
    assign addr_in_range = ({1'b0, reg_addr} < REG_LIMIT);
    assign rd_val        = (reg_addr == 5'd0) ? DEVICE_ID :
                           addr_in_range      ? reg_file[reg_addr] : 8'h00;

    assign new_word = CONV_VALID ? CONV_DATA : pend_data;

`ifdef ADS124S08_RESP_CRC_EN
    function automatic logic [7:0] crc8(input logic [23:0] d);
        logic [7:0] c;
        c = 8'hFF;
        for (int i = 23; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign new_tail = crc8(new_word);
`else
    assign new_tail = 8'h00;
`endif

    // Synchronize the SPI pins and keep one-cycle history for edge detection;
    // nCS starts low so a frame can only begin after nCS has been seen high.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sclk_sync <= '0;
            ncs_sync  <= '0;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ncs_prev  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], ADC_SCLK};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ADC_nCS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], ADC_MOSI};
            sclk_prev <= sclk_s;
            ncs_prev  <= ncs_s;
        end
    end

    // Frame state machine: bit counting, opcode decode, MISO launch and register writes.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= ST_IDLE;
            bit_cnt       <= 6'd0;
            rx_shift      <= 7'd0;
            shift_out     <= 32'd0;
            reg_addr      <= 5'd0;
            is_wreg       <= 1'b0;
            direct_24     <= 1'b0;
            ADC_MISO      <= 1'b0;
            REG_WR_STROBE <= 1'b0;
            REG_WR_ADDR   <= 5'd0;
            REG_WR_DATA   <= 8'd0;
            FRAME_ERR     <= 1'b0;
            for (int i = 1; i < REG_COUNT; i++) reg_file[i] <= 8'h00;
        end else begin
            REG_WR_STROBE <= 1'b0;
            FRAME_ERR     <= 1'b0;
            if (ncs_rise) begin
                state    <= ST_IDLE;
                ADC_MISO <= 1'b0;
                if (state != ST_IDLE && bit_cnt[2:0] != 3'd0) FRAME_ERR <= 1'b1;
            end else if (ncs_fall) begin
                state     <= ST_CMD;
                bit_cnt   <= 6'd0;
                direct_24 <= 1'b0;
                shift_out <= {conv_data, conv_tail};
                ADC_MISO  <= conv_data[23];
            end else if (state != ST_IDLE) begin
                if (sclk_rise) begin
                    if (state == ST_DONE || bit_cnt[5]) ADC_MISO <= 1'b0;
                    else                                ADC_MISO <= shift_out[out_idx];
                end
                if (sclk_fall && state != ST_DONE) begin
                    rx_shift <= next_byte[6:0];
                    bit_cnt  <= bit_cnt + 6'd1;
                    case (state)
                        ST_CMD: begin
                            if (bit_cnt == 6'd7) begin
                                reg_addr <= next_byte[4:0];
                                if (next_byte[7:5] == 3'b010) begin
                                    is_wreg <= 1'b1;
                                    state   <= ST_ARG;
                                end else if (next_byte[7:5] == 3'b001) begin
                                    is_wreg <= 1'b0;
                                    state   <= ST_ARG;
                                end else begin
                                    state   <= ST_DIRECT;
                                end
                            end
                        end
                        ST_ARG: begin
                            if (bit_cnt == 6'd15) begin
                                state <= ST_DATA;
                                if (!is_wreg) shift_out[15:8] <= rd_val;
                            end
                        end
                        ST_DATA: begin
                            if (bit_cnt == 6'd23) begin
                                state <= ST_DONE;
                                if (is_wreg && reg_addr != 5'd0 && addr_in_range) begin
                                    reg_file[reg_addr] <= next_byte;
                                    REG_WR_STROBE      <= 1'b1;
                                    REG_WR_ADDR        <= reg_addr;
                                    REG_WR_DATA        <= next_byte;
                                end
                            end
                        end
                        ST_DIRECT: begin
                            if (bit_cnt == 6'd23) direct_24 <= 1'b1;
                            if (bit_cnt == 6'd31) state <= ST_DONE;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Conversion holding register and nDRDY; words arriving mid-frame wait until nCS rises.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            conv_data <= 24'd0;
            conv_tail <= 8'd0;
            pend_data <= 24'd0;
            pending   <= 1'b0;
            ADC_nDRDY <= 1'b1;
        end else if (ncs_rise) begin
            if (CONV_VALID || pending) begin
                conv_data <= new_word;
                conv_tail <= new_tail;
                pending   <= 1'b0;
                ADC_nDRDY <= 1'b0;
            end else if (direct_24) begin
                ADC_nDRDY <= 1'b1;
            end
        end else if (CONV_VALID) begin
            if (!ncs_s) begin
                pend_data <= CONV_DATA;
                pending   <= 1'b1;
            end else begin
                conv_data <= CONV_DATA;
                conv_tail <= new_tail;
                ADC_nDRDY <= 1'b0;
            end
        end
    end

endmodule
